// File: rtl/poca_pkg.sv
// Shared types and widths for the POCA window sequencer.
// State encoding, counter/window width and default event width.
package poca_pkg;

  localparam int CNT_W     = 32;
  localparam int EVT_W_DEF = 32;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    LOAD,
    RUN,
    DONE
  } state_e;

  function automatic logic is_zero(
    input logic [CNT_W-1:0] v
  );
    return (v == '0);
  endfunction

endpackage

// File: rtl/cnt_window_ctrl_if.sv
// Host-side request/result handshake of the window sequencer.
// master: host (req, cycle_in, result_ack); slave: sequencer.
interface cnt_window_ctrl_if #(
  parameter int EVT_W = poca_pkg::EVT_W_DEF
);
  import poca_pkg::*;

  logic             req;
  logic [CNT_W-1:0] cycle_in;
  logic             busy;
  logic [EVT_W-1:0] result;
  logic             result_valid;
  logic             result_ack;

  modport master (
    output req,
    output cycle_in,
    output result_ack,
    input  busy,
    input  result,
    input  result_valid
  );

  modport slave (
    input  req,
    input  cycle_in,
    input  result_ack,
    output busy,
    output result,
    output result_valid
  );

endinterface

// File: rtl/counter.sv
// POCA down-counter: cnt_rst clears, cnt_load loads cycle, start_cnt
// decrements; cnt_done is sticky and set as the count reaches zero.
module counter
  import poca_pkg::*;
(
  input  logic             clk,
  input  logic             cnt_rst,
  input  logic             cnt_load,
  input  logic             start_cnt,
  input  logic [CNT_W-1:0] cycle,
  output logic             cnt_done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (cnt_rst) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (cnt_load) begin
      cnt_d = cycle;
    end else if (start_cnt) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        done_d = 1'b1;
      end
    end
  end

  // No global reset: only cnt_rst makes this counter clean.
  always_ff @(posedge clk) begin
    cnt_q  <= cnt_d;
    done_q <= done_d;
  end

  assign cnt_done = done_q;

endmodule

// File: rtl/sync_edge.sv
// STAGES-deep synchronizer with a registered one-cycle rise pulse.
// Ports: clk, rst (sync, active-high), d (async in), rise (pulse).
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;
  logic              rise_q, rise_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
    rise_d = sync_q[STAGES-1] & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/cnt_window_ctrl.sv
// Opens a cycle_in-clock window on the POCA counter and counts evt_in
// rises in it. Ports: clk, rst, host handshake, counter controls, evt_in.
module cnt_window_ctrl
  import poca_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int EVT_W       = EVT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  cnt_window_ctrl_if.slave       host,
  output logic                   cnt_rst,
  output logic                   cnt_load,
  output logic                   start_cnt,
  output logic [CNT_W-1:0]       cycle,
  input  logic                   cnt_done,
  input  logic                   evt_in
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [EVT_W-1:0] evt_q, evt_d;
  logic [EVT_W-1:0] result_q, result_d;
  logic             evt_rise;

  sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (evt_in),
    .rise (evt_rise)
  );

  always_comb begin
    state_d  = state_q;
    cycle_d  = cycle_q;
    evt_d    = evt_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (host.req) begin
          cycle_d  = host.cycle_in;
          evt_d    = '0;
          result_d = '0;
          // A zero window would wrap the counter; skip it.
          if (is_zero(host.cycle_in)) begin
            state_d = DONE;
          end else begin
            state_d = CLR;
          end
        end
      end
      CLR:  state_d = LOAD;
      LOAD: state_d = RUN;
      RUN: begin
        if (cnt_done) begin
          result_d = evt_q;
          state_d  = DONE;
        end else if (evt_rise && !(&evt_q)) begin
          evt_d = evt_q + 1'b1;
        end
      end
      DONE: begin
        if (host.result_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cycle_q  <= '0;
      evt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cycle_q  <= cycle_d;
      evt_q    <= evt_d;
      result_q <= result_d;
    end
  end

  assign host.busy         = (state_q != IDLE);
  assign host.result_valid = (state_q == DONE);
  assign host.result       = result_q;
  assign cnt_rst           = (state_q == CLR);
  assign cnt_load          = (state_q == LOAD);
  assign start_cnt         = (state_q == RUN) & ~cnt_done;
  assign cycle             = cycle_q;

endmodule

// File: tb/tb_cnt_window_ctrl.sv
// Directed bench for cnt_window_ctrl driving a real counter.
// Two instances: EVT_W=32 main, EVT_W=4 for saturation.
module tb_cnt_window_ctrl;
  import poca_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic evt_in;

  cnt_window_ctrl_if #(.EVT_W(32)) hif ();
  cnt_window_ctrl_if #(.EVT_W(4))  hif4 ();

  logic        cnt_rst, cnt_load, start_cnt, cnt_done;
  logic [31:0] cycle;
  logic        cnt_rst4, cnt_load4, start_cnt4, cnt_done4;
  logic [31:0] cycle4;

  cnt_window_ctrl #(.SYNC_STAGES(2), .EVT_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .host      (hif),
    .cnt_rst   (cnt_rst),
    .cnt_load  (cnt_load),
    .start_cnt (start_cnt),
    .cycle     (cycle),
    .cnt_done  (cnt_done),
    .evt_in    (evt_in)
  );

  counter u_cnt (
    .clk       (clk),
    .cnt_rst   (cnt_rst),
    .cnt_load  (cnt_load),
    .start_cnt (start_cnt),
    .cycle     (cycle),
    .cnt_done  (cnt_done)
  );

  cnt_window_ctrl #(.SYNC_STAGES(2), .EVT_W(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .host      (hif4),
    .cnt_rst   (cnt_rst4),
    .cnt_load  (cnt_load4),
    .start_cnt (start_cnt4),
    .cycle     (cycle4),
    .cnt_done  (cnt_done4),
    .evt_in    (evt_in)
  );

  counter u_cnt4 (
    .clk       (clk),
    .cnt_rst   (cnt_rst4),
    .cnt_load  (cnt_load4),
    .start_cnt (start_cnt4),
    .cycle     (cycle4),
    .cnt_done  (cnt_done4)
  );

  int checks   = 0;
  int failures = 0;
  int evt_mode = 0;
  int evt_div  = 0;

  // e_k history: after posedge k, ehist[i] = evt_in sampled at k-i.
  logic [3:0] ehist = 4'b0;
  always @(posedge clk) ehist <= {ehist[2:0], evt_in};

  task automatic step();
    @(posedge clk);
    #1;
    if (evt_mode == 1) begin
      evt_div = evt_div + 1;
      if (evt_div == 4) begin
        evt_div = 0;
        evt_in  = ~evt_in;
      end
    end else if (evt_mode == 2) begin
      evt_in = ~evt_in;
    end
  endtask

  task automatic run_window(
    input  logic [31:0] n,
    output int          n_rst,
    output int          rst_at,
    output int          n_load,
    output int          load_at,
    output int          nstart,
    output int          sfirst,
    output int          lat,
    output int          nbusy0,
    output logic [31:0] mcnt
  );
    int s;
    n_rst = 0; rst_at = -1; n_load = 0; load_at = -1;
    nstart = 0; sfirst = -1; lat = -1; nbusy0 = 0;
    mcnt = 0;
    hif.req      = 1'b1;
    hif.cycle_in = n;
    step();
    hif.req = 1'b0;
    s = 1;
    while (lat < 0 && s <= int'(n) + 40) begin
      if (cnt_rst) begin n_rst++; rst_at = s; end
      if (cnt_load) begin n_load++; load_at = s; end
      if (start_cnt) begin
        nstart++;
        if (sfirst < 0) sfirst = s;
      end
      if (!hif.busy) nbusy0++;
      // Window is cycles t+3..t+N+2; pulse = e[k-2] & ~e[k-3].
      if (s >= 3 && s <= int'(n) + 2 && ehist[2] && !ehist[3])
        mcnt++;
      if (hif.result_valid) lat = s;
      else begin
        step();
        s++;
      end
    end
  endtask

  task automatic do_ack();
    hif.result_ack = 1'b1;
    step();
    hif.result_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    hif.req = 1'b0; hif.cycle_in = '0; hif.result_ack = 1'b0;
    hif4.req = 1'b0; hif4.cycle_in = '0; hif4.result_ack = 1'b0;
    evt_mode = 0; evt_in = 1'b0;
    repeat (3) step();
    checks++;
    if ({hif.busy, cnt_rst, cnt_load, start_cnt, hif.result_valid} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctl got=%b exp=00000",
        {hif.busy, cnt_rst, cnt_load, start_cnt, hif.result_valid});
    end
    checks++;
    if (cycle !== 32'd0) begin
      failures++;
      $display("FAIL reset_cycle got=%0d exp=0", cycle);
    end
    checks++;
    if (hif.result !== 32'd0) begin
      failures++;
      $display("FAIL reset_result got=%0d exp=0", hif.result);
    end
    checks++;
    if ({hif4.busy, cnt_rst4, cnt_load4, start_cnt4, hif4.result_valid} !== 5'b0) begin
      failures++;
      $display("FAIL reset4_ctl got=%b exp=00000",
        {hif4.busy, cnt_rst4, cnt_load4, start_cnt4, hif4.result_valid});
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int nr, ra, nl, la, ns, sf, lat, nb;
    logic [31:0] m;
    evt_in = 1'b0; evt_div = 0; evt_mode = 1;
    run_window(32'd10, nr, ra, nl, la, ns, sf, lat, nb, m);
    checks++;
    if (nr !== 1 || ra !== 1) begin
      failures++;
      $display("FAIL basic_clr got=%0d@%0d exp=1@1", nr, ra);
    end
    checks++;
    if (nl !== 1 || la !== 2) begin
      failures++;
      $display("FAIL basic_load got=%0d@%0d exp=1@2", nl, la);
    end
    checks++;
    if (ns !== 10 || sf !== 3) begin
      failures++;
      $display("FAIL basic_start got=%0d@%0d exp=10@3", ns, sf);
    end
    checks++;
    if (lat !== 14) begin
      failures++;
      $display("FAIL basic_valid_lat got=%0d exp=14", lat);
    end
    checks++;
    if (nb !== 0) begin
      failures++;
      $display("FAIL basic_busy got=%0d_low exp=0_low", nb);
    end
    checks++;
    if (hif.result !== m || m < 1 || m > 2) begin
      failures++;
      $display("FAIL basic_result got=%0d exp=%0d", hif.result, m);
    end
    do_ack();
    checks++;
    if (hif.result_valid !== 1'b0 || hif.busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_ack got=%b%b exp=00",
        hif.result_valid, hif.busy);
    end
  endtask

  task automatic test_zero_length();
    int nr, ra, nl, la, ns, sf, lat, nb;
    logic [31:0] m;
    run_window(32'd0, nr, ra, nl, la, ns, sf, lat, nb, m);
    checks++;
    if (lat !== 1) begin
      failures++;
      $display("FAIL zero_valid_lat got=%0d exp=1", lat);
    end
    checks++;
    if (nr !== 0 || nl !== 0 || ns !== 0) begin
      failures++;
      $display("FAIL zero_ctl got=%0d/%0d/%0d exp=0/0/0", nr, nl, ns);
    end
    checks++;
    if (hif.result !== 32'd0 || nb !== 0) begin
      failures++;
      $display("FAIL zero_result got=%0d busy_low=%0d exp=0",
        hif.result, nb);
    end
    do_ack();
  endtask

  task automatic test_back_to_back();
    int nr, ra, nl, la, ns, sf, lat, nb;
    logic [31:0] m;
    evt_mode = 0; evt_in = 1'b1;
    repeat (6) step();
    run_window(32'd5, nr, ra, nl, la, ns, sf, lat, nb, m);
    checks++;
    if (ra !== 1 || la !== 2) begin
      failures++;
      $display("FAIL b2b1_seq got=clr%0d_load%0d exp=clr1_load2", ra, la);
    end
    checks++;
    if (ns !== 5 || lat !== 9) begin
      failures++;
      $display("FAIL b2b1_win got=%0d/%0d exp=5/9", ns, lat);
    end
    checks++;
    if (hif.result !== 32'd0) begin
      failures++;
      $display("FAIL b2b1_result got=%0d exp=0", hif.result);
    end
    do_ack();
    run_window(32'd3, nr, ra, nl, la, ns, sf, lat, nb, m);
    checks++;
    if (nr !== 1 || ra !== 1 || la !== 2) begin
      failures++;
      $display("FAIL b2b2_seq got=%0d@%0d/%0d exp=1@1/2", nr, ra, la);
    end
    checks++;
    if (ns !== 3 || lat !== 7) begin
      failures++;
      $display("FAIL b2b2_win got=%0d/%0d exp=3/7", ns, lat);
    end
    checks++;
    if (hif.result !== 32'd0) begin
      failures++;
      $display("FAIL b2b2_result got=%0d exp=0", hif.result);
    end
    do_ack();
  endtask

  task automatic test_ack_protocol();
    int nr, ra, nl, la, ns, sf, lat, nb;
    logic [31:0] m;
    logic [31:0] r;
    evt_in = 1'b0; evt_div = 0; evt_mode = 1;
    repeat (4) step();
    run_window(32'd10, nr, ra, nl, la, ns, sf, lat, nb, m);
    r = hif.result;
    checks++;
    if (r !== m || lat !== 14) begin
      failures++;
      $display("FAIL ack_run got=%0d@%0d exp=%0d@14", r, lat, m);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (hif.result_valid !== 1'b1 || hif.result !== r) begin
        failures++;
        $display("FAIL ack_hold got=%b/%0d exp=1/%0d",
          hif.result_valid, hif.result, r);
      end
    end
    hif.result_ack = 1'b1;
    hif.req        = 1'b1;
    hif.cycle_in   = 32'd5;
    step();
    hif.result_ack = 1'b0;
    hif.req        = 1'b0;
    checks++;
    if (hif.result_valid !== 1'b0 || hif.busy !== 1'b0) begin
      failures++;
      $display("FAIL ack_fall got=%b%b exp=00",
        hif.result_valid, hif.busy);
    end
    checks++;
    if (hif.result !== r) begin
      failures++;
      $display("FAIL ack_keep got=%0d exp=%0d", hif.result, r);
    end
    step();
    checks++;
    if (hif.busy !== 1'b0 || cnt_rst !== 1'b0) begin
      failures++;
      $display("FAIL ack_req_ignored got=%b%b exp=00",
        hif.busy, cnt_rst);
    end
  endtask

  task automatic test_reset_mid_run();
    int nr, ra, nl, la, ns, sf, lat, nb;
    logic [31:0] m;
    evt_mode = 1;
    hif.req = 1'b1; hif.cycle_in = 32'd100;
    step();
    hif.req = 1'b0;
    for (int s = 1; s < 42; s++) step();
    checks++;
    if (start_cnt !== 1'b1 || cycle !== 32'd100) begin
      failures++;
      $display("FAIL midrun_pre got=%b/%0d exp=1/100", start_cnt, cycle);
    end
    rst = 1'b1;
    step();
    checks++;
    if ({hif.busy, cnt_rst, cnt_load, start_cnt, hif.result_valid} !== 5'b0) begin
      failures++;
      $display("FAIL midrun_ctl got=%b exp=00000",
        {hif.busy, cnt_rst, cnt_load, start_cnt, hif.result_valid});
    end
    checks++;
    if (cycle !== 32'd0 || hif.result !== 32'd0) begin
      failures++;
      $display("FAIL midrun_data got=%0d/%0d exp=0/0", cycle, hif.result);
    end
    rst = 1'b0;
    repeat (5) step();
    run_window(32'd7, nr, ra, nl, la, ns, sf, lat, nb, m);
    checks++;
    if (ra !== 1 || la !== 2 || ns !== 7 || sf !== 3) begin
      failures++;
      $display("FAIL midrun_rerun got=%0d/%0d/%0d@%0d exp=1/2/7@3",
        ra, la, ns, sf);
    end
    checks++;
    if (lat !== 11 || hif.result !== m) begin
      failures++;
      $display("FAIL midrun_result got=%0d@%0d exp=%0d@11",
        hif.result, lat, m);
    end
    do_ack();
  endtask

  task automatic test_saturation();
    int s, lat, ns;
    evt_mode = 2;
    hif4.req = 1'b1; hif4.cycle_in = 32'd64;
    step();
    hif4.req = 1'b0;
    s = 1; lat = -1; ns = 0;
    while (lat < 0 && s <= 120) begin
      if (start_cnt4) ns++;
      if (hif4.result_valid) lat = s;
      else begin
        step();
        s++;
      end
    end
    checks++;
    if (lat !== 68 || ns !== 64) begin
      failures++;
      $display("FAIL sat_window got=%0d@%0d exp=64@68", ns, lat);
    end
    checks++;
    if (hif4.result !== 4'hF) begin
      failures++;
      $display("FAIL sat_result got=%0d exp=15", hif4.result);
    end
    hif4.result_ack = 1'b1;
    step();
    hif4.result_ack = 1'b0;
    checks++;
    if (hif4.result_valid !== 1'b0 || hif4.result !== 4'hF) begin
      failures++;
      $display("FAIL sat_ack got=%b/%0d exp=0/15",
        hif4.result_valid, hif4.result);
    end
    evt_mode = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_length();
    test_back_to_back();
    test_ack_protocol();
    test_reset_mid_run();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
